// File: rtl/layer_output_streamer.sv
// Snapshots an N-element vector from a flattened bus on a capture pulse and
// streams it one element per valid/ready transfer, with back-to-back recapture.
module layer_output_streamer #(
   parameter int N  = 256,
   parameter int W  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cap_valid,
   input  logic [N*W-1:0]  cap_data,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [W-1:0]    m_data,
   output logic [IW-1:0]   m_index,
   output logic            m_last,
   output logic            busy,
   output logic            drop_err
);

   // state   | meaning
   // S_IDLE  | no vector held, outputs zero, waiting for cap_valid
   // S_STREAM| vector held, presenting vec[idx] until the last beat drains
   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t           state_q, state_d;
   logic [N*W-1:0]   vec_q, vec_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             drop_q, drop_d;

   logic is_stream;
   logic at_last;
   logic xfer;

   assign is_stream = (state_q == S_STREAM);
   assign at_last   = (idx_q == IW'(N - 1));
   assign xfer      = is_stream & m_ready;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: begin
            if (cap_valid) begin
               vec_d   = cap_data;
               idx_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (xfer && at_last) begin
               idx_d = '0;
               if (cap_valid) vec_d = cap_data;
               else           state_d = S_IDLE;
            end else begin
               if (xfer)      idx_d  = idx_q + IW'(1);
               if (cap_valid) drop_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
      end
   end

   // Buffer contents are don't-care out of reset; the IDLE gating below hides them.
   always_ff @(posedge clk) begin
      vec_q <= vec_d;
   end

   assign m_valid  = is_stream;
   assign busy     = is_stream;
   assign m_data   = is_stream ? vec_q[int'(idx_q)*W +: W] : '0;
   assign m_index  = is_stream ? idx_q : '0;
   assign m_last   = is_stream & at_last;
   assign drop_err = drop_q;

endmodule

// File: tb/tb_layer_output_streamer.sv
// Directed bench for layer_output_streamer: a queue-based beat model is checked
// against the DUT every cycle, plus literal expectations at key points.
module tb_layer_output_streamer;
   localparam int N  = 256;
   localparam int W  = 16;
   localparam int IW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            cap_valid;
   logic [N*W-1:0]  cap_data;
   logic            m_valid;
   logic            m_ready;
   logic [W-1:0]    m_data;
   logic [IW-1:0]   m_index;
   logic            m_last;
   logic            busy;
   logic            drop_err;

   layer_output_streamer #(.N(N), .W(W), .IW(IW)) dut (
      .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_data(cap_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_index(m_index), .m_last(m_last), .busy(busy), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining beats of the accepted vector, in order.
   logic [W-1:0] q_data[$];
   int           q_idx[$];
   bit           m_drop = 1'b0;
   int           popped = 0;

   always @(posedge clk) begin
      if (rst) begin
         q_data.delete();
         q_idx.delete();
         m_drop = 1'b0;
      end else begin
         bit xfer, last, accept;
         xfer   = (q_data.size() != 0) && m_ready;
         last   = xfer && (q_idx[0] == N - 1);
         accept = cap_valid && ((q_data.size() == 0) || last);
         if (cap_valid && !accept) m_drop = 1'b1;
         if (xfer) begin
            void'(q_data.pop_front());
            void'(q_idx.pop_front());
            popped++;
         end
         if (accept)
            for (int i = 0; i < N; i++) begin
               q_data.push_back(cap_data[i*W +: W]);
               q_idx.push_back(i);
            end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit ev;
         ev = (q_data.size() != 0);
         check("m_valid", 32'(m_valid), 32'(ev));
         check("busy", 32'(busy), 32'(ev));
         check("drop_err", 32'(drop_err), 32'(m_drop));
         check("m_data", 32'(m_data), ev ? 32'(q_data[0]) : 32'd0);
         check("m_index", 32'(m_index), ev ? 32'(q_idx[0]) : 32'd0);
         check("m_last", 32'(m_last), 32'(ev && q_idx[0] == N - 1));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] ramp();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
      return v;
   endfunction

   function automatic logic [N*W-1:0] fill(input logic [W-1:0] e);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = e;
      return v;
   endfunction

   task automatic start(input logic [N*W-1:0] v);
      cap_data  = v;
      cap_valid = 1'b1;
      cyc();
      cap_valid = 1'b0;
      cap_data  = ~v;   // bus changes after capture must not leak into the stream
   endtask

   // Drain while busy; optional second capture / reset at beat-cycle n.
   task automatic run(input bit alt, input int cap_at, input int rst_at, output int n);
      n = 0;
      while (busy && n < 2000) begin
         m_ready   = alt ? (n % 2 == 0) : 1'b1;
         cap_valid = (n == cap_at);
         if (n == cap_at) cap_data = fill(16'h0100);
         rst       = (n == rst_at);
         cyc();
         cap_valid = 1'b0;
         rst       = 1'b0;
         n++;
         if (cap_at == 255 && n == 256) begin
            check("recap_valid", 32'(m_valid), 32'd1);
            check("recap_index", 32'(m_index), 32'd0);
            check("recap_data", 32'(m_data), 32'h0100);
         end
      end
   endtask

   initial begin
      int n, p0;
      logic [N*W-1:0] v;
      rst = 1'b1; cap_valid = 1'b0; m_ready = 1'b0; cap_data = '0;
      cyc(); cyc();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_drop", 32'(drop_err), 32'd0);
      m_ready = 1'b1;
      cyc(); cyc();

      // 1: ramp, ready held high
      p0 = popped;
      start(ramp());
      check("t1_first_data", 32'(m_data), 32'h0000);
      run(1'b0, -1, -1, n);
      check("t1_cycles", n, 256);
      check("t1_beats", popped - p0, 256);
      check("t1_drop", 32'(drop_err), 32'd0);

      // 2: ramp, ready alternating
      p0 = popped;
      start(ramp());
      run(1'b1, -1, -1, n);
      check("t2_cycles", n, 511);
      check("t2_beats", popped - p0, 256);
      m_ready = 1'b1;
      cyc();

      // 3: refused capture at beat 10
      p0 = popped;
      start(ramp());
      run(1'b0, 10, -1, n);
      check("t3_cycles", n, 256);
      check("t3_beats", popped - p0, 256);
      check("t3_drop_sticky", 32'(drop_err), 32'd1);
      rst = 1'b1; cyc(); rst = 1'b0;
      check("t3_drop_cleared", 32'(drop_err), 32'd0);

      // 4: recapture on the last beat
      p0 = popped;
      start(ramp());
      run(1'b0, 255, -1, n);
      check("t4_cycles", n, 512);
      check("t4_beats", popped - p0, 512);
      check("t4_drop", 32'(drop_err), 32'd0);

      // 5: reset mid-stream at beat 100, then all-0xFFFF vector
      start(ramp());
      run(1'b0, -1, 100, n);
      check("t5_cycles", n, 101);
      check("t5_valid", 32'(m_valid), 32'd0);
      check("t5_data", 32'(m_data), 32'd0);
      check("t5_index", 32'(m_index), 32'd0);
      cyc();
      start(fill(16'hFFFF));
      check("t5_restart_index", 32'(m_index), 32'd0);
      check("t5_restart_data", 32'(m_data), 32'hFFFF);
      run(1'b0, -1, -1, n);
      check("t5_cycles2", n, 256);

      // 6: signed extremes pass through bit-exact
      v = ramp();
      v[0*W +: W] = 16'h8000;
      v[1*W +: W] = 16'h7FFF;
      v[2*W +: W] = 16'hFFFF;
      start(v);
      check("t6_e0", 32'(m_data), 32'h8000);
      cyc();
      check("t6_e1", 32'(m_data), 32'h7FFF);
      cyc();
      check("t6_e2", 32'(m_data), 32'hFFFF);
      run(1'b0, -1, -1, n);
      check("t6_cycles", n, 254);
      cyc();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
